// File: rtl/trigger_pkg.sv
// Shared mode encodings and FSM state type for the multi-channel trigger shaper.
package trigger_pkg;

    localparam logic [1:0] TRIG_MODE_FORCE = 2'd0;
    localparam logic [1:0] TRIG_MODE_OR    = 2'd1;
    localparam logic [1:0] TRIG_MODE_COINC = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLDOFF
    } trig_state_t;

    // Mode 3 is an alias of OR; folding it early keeps mode-change detection honest.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? TRIG_MODE_OR : m;
    endfunction

endpackage

// File: rtl/trigger_chan_shaper.sv
// One trigger channel: synchroniser, rising-edge detect and retriggerable width counter.
module trigger_chan_shaper #(
    parameter int SYNC_STAGES = 3,
    parameter int WIDTH_W     = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trig_i,
    input  logic               enable_i,
    input  logic               block_i,
    input  logic [WIDTH_W-1:0] width_i,
    output logic               active_o
);

    logic [SYNC_STAGES:0] sync_q;
    logic [WIDTH_W-1:0]   cnt_q;
    logic [WIDTH_W-1:0]   cnt_d;
    logic                 edge_det;

    assign edge_det = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (!enable_i) begin
            cnt_d = '0;
        end else if (edge_det && !block_i) begin
            cnt_d = (width_i == '0) ? WIDTH_W'(1) : width_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: non-blocking assignments so the synchroniser shifts one stage per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], trig_i};
            cnt_q  <= cnt_d;
        end
    end

    assign active_o = (cnt_q != '0);

endmodule

// File: rtl/trigger_shaper_mc.sv
// Multi-channel trigger conditioner: per-channel stretching, OR/coincidence combine,
// post-trigger holdoff and a saturating accepted-trigger counter.
module trigger_shaper_mc
    import trigger_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 3,
    parameter int WIDTH_W     = 10,
    parameter int HOLDOFF_W   = 8,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH-1:0]            trig_in,
    input  logic [N_CH-1:0]            ch_enable,
    input  logic [1:0]                 mode,
    input  logic [$clog2(N_CH+1)-1:0]  coinc_min,
    input  logic [WIDTH_W-1:0]         trigger_width,
    input  logic [HOLDOFF_W-1:0]       holdoff,
    input  logic                       count_clr,
    output logic [N_CH-1:0]            ch_active,
    output logic                       trigger_out,
    output logic [CNT_W-1:0]           trig_count
);

    localparam int CM_W = $clog2(N_CH+1);

    trig_state_t          state_q, state_d;
    logic [HOLDOFF_W-1:0] ho_q, ho_d;
    logic [1:0]           mode_q;
    logic [1:0]           cur_mode;
    logic [CNT_W-1:0]     cnt_q;
    logic                 trig_q;
    logic [CM_W-1:0]      pop;
    logic [CM_W-1:0]      thresh;
    logic                 hit;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        trigger_chan_shaper #(
            .SYNC_STAGES (SYNC_STAGES),
            .WIDTH_W     (WIDTH_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .trig_i   (trig_in[g]),
            .enable_i (ch_enable[g]),
            .block_i  (state_q == HOLDOFF),
            .width_i  (trigger_width),
            .active_o (ch_active[g])
        );
    end

    assign cur_mode = norm_mode(mode);
    assign thresh   = (coinc_min == '0) ? CM_W'(1) : coinc_min;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            pop = pop + CM_W'(ch_active[i]);
        end
        hit = (cur_mode == TRIG_MODE_COINC) ? (pop >= thresh) : (pop != '0);
    end

    // Any mode change parks the FSM in IDLE for one cycle before hit is re-evaluated.
    always_comb begin
        state_d = state_q;
        ho_d    = ho_q;
        if (cur_mode == TRIG_MODE_FORCE || cur_mode != mode_q) begin
            state_d = IDLE;
            ho_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) state_d = ACTIVE;
                end
                ACTIVE: begin
                    if (!hit) begin
                        if (holdoff != '0) begin
                            state_d = HOLDOFF;
                            ho_d    = holdoff;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                HOLDOFF: begin
                    if (ho_q <= HOLDOFF_W'(1)) state_d = IDLE;
                    else                       ho_d    = ho_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ho_q    <= '0;
            mode_q  <= TRIG_MODE_FORCE;
            trig_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ho_q    <= ho_d;
            mode_q  <= cur_mode;
            trig_q  <= (cur_mode == TRIG_MODE_FORCE) || (state_d == ACTIVE);
            if (count_clr) begin
                cnt_q <= '0;
            end else if (state_q == IDLE && state_d == ACTIVE && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign trigger_out = trig_q;
    assign trig_count  = cnt_q;

endmodule

// File: tb/tb_trigger_shaper_mc.sv
// Directed and randomized bench for trigger_shaper_mc against a timeline-based reference model.
module tb_trigger_shaper_mc;

    localparam int N_CH    = 4;
    localparam int S       = 3;
    localparam int WIDTH_W = 10;
    localparam int HO_W    = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_CH-1:0]   trig_in = '0;
    logic [N_CH-1:0]   ch_enable = '1;
    logic [1:0]        mode = 2'd1;
    logic [2:0]        coinc_min = '0;
    logic [WIDTH_W-1:0] trigger_width = 10'd5;
    logic [HO_W-1:0]   holdoff = '0;
    logic              count_clr = 1'b0;
    logic [N_CH-1:0]   ch_active;
    logic              trigger_out;
    logic [CNT_W-1:0]  trig_count;

    trigger_shaper_mc #(
        .N_CH(N_CH), .SYNC_STAGES(S), .WIDTH_W(WIDTH_W), .HOLDOFF_W(HO_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .ch_enable(ch_enable), .mode(mode),
        .coinc_min(coinc_min), .trigger_width(trigger_width), .holdoff(holdoff),
        .count_clr(count_clr), .ch_active(ch_active), .trigger_out(trigger_out),
        .trig_count(trig_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: each channel is a "last active edge index"; the global FSM is an
    // on/off flag plus the last edge index of the dead window.
    int n = 0;
    bit samp [N_CH][$];
    int act_end [N_CH];
    bit m_on;
    int dead_end;
    int m_count;
    int prev_mode;

    int act_hi [N_CH];
    int trg_hi;
    int first_act, first_trg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            samp[c].delete();
            for (int k = 0; k <= S; k++) samp[c].push_back(1'b0);
            act_end[c] = -1;
        end
        m_on = 1'b0;
        dead_end = -1;
        m_count = 0;
        prev_mode = 0;
    endtask

    task automatic clear_stats();
        for (int c = 0; c < N_CH; c++) act_hi[c] = 0;
        trg_hi = 0;
        first_act = -1;
        first_trg = -1;
    endtask

    task automatic tick();
        int e, em, pc, th, w;
        bit hit, in_ho, rose, edge_d, exp_trig;
        logic [N_CH-1:0] act_pre, exp_act;
        e = n + 1;
        for (int c = 0; c < N_CH; c++) act_pre[c] = (n <= act_end[c]);
        em = (mode == 2'd3) ? 1 : int'(mode);
        pc = $countones(act_pre);
        th = (coinc_min == 0) ? 1 : int'(coinc_min);
        hit = (em == 2) ? (pc >= th) : (pc != 0);
        in_ho = (n <= dead_end);
        w = (trigger_width == 0) ? 1 : int'(trigger_width);
        for (int c = 0; c < N_CH; c++) begin
            edge_d = samp[c][S-1] & ~samp[c][S];
            if (!ch_enable[c]) act_end[c] = -1;
            else if (edge_d && !in_ho) act_end[c] = e + w - 1;
            samp[c].push_front(trig_in[c]);
            void'(samp[c].pop_back());
        end
        rose = 1'b0;
        if (em == 0 || em != prev_mode) begin
            m_on = 1'b0;
            dead_end = -1;
        end else if (m_on) begin
            if (!hit) begin
                m_on = 1'b0;
                if (holdoff != 0) dead_end = e + int'(holdoff) - 1;
            end
        end else if (!in_ho && hit) begin
            m_on = 1'b1;
            rose = 1'b1;
        end
        if (count_clr) m_count = 0;
        else if (rose && m_count < CNT_MAX) m_count++;
        exp_trig = (em == 0) || m_on;
        prev_mode = em;

        @(posedge clk);
        n = e;
        #1;
        for (int c = 0; c < N_CH; c++) exp_act[c] = (n <= act_end[c]);
        check("ch_active", 32'(ch_active), 32'(exp_act));
        check("trigger_out", 32'(trigger_out), 32'(exp_trig));
        check("trig_count", 32'(trig_count), 32'(m_count));
        for (int c = 0; c < N_CH; c++) act_hi[c] += int'(ch_active[c]);
        trg_hi += int'(trigger_out);
        if (ch_active[0] && first_act < 0) first_act = n;
        if (trigger_out && first_trg < 0) first_trg = n;
    endtask

    // Called #1 after a rising edge; reset takes effect without waiting for the clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ch_active", 32'(ch_active), 32'd0);
        check("rst_trigger_out", 32'(trigger_out), 32'd0);
        check("rst_trig_count", 32'(trig_count), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse(input logic [N_CH-1:0] ch, input int idle_ticks);
        trig_in = ch;
        tick();
        trig_in = '0;
        repeat (idle_ticks) tick();
    endtask

    int snap;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_trigger_out", 32'(trigger_out), 32'd0);
        check("reset_trig_count", 32'(trig_count), 32'd0);

        // Scenario 1: OR, width 5, no holdoff.
        clear_stats();
        pulse(4'b0001, 10);
        check("s1_act_cycles", act_hi[0], 5);
        check("s1_trg_cycles", trg_hi, 5);
        check("s1_trg_delay", first_trg - first_act, 1);
        check("s1_count", 32'(trig_count), 32'd1);

        // Scenario 2: width 0 gives one cycle; retrigger extends a width-4 pulse to 6.
        trigger_width = 10'd0;
        clear_stats();
        pulse(4'b0010, 6);
        check("s2_w0_act", act_hi[1], 1);
        check("s2_w0_trg", trg_hi, 1);
        trigger_width = 10'd4;
        clear_stats();
        trig_in = 4'b0010; tick();
        trig_in = 4'b0000; tick();
        trig_in = 4'b0010; tick();
        trig_in = 4'b0000;
        repeat (10) tick();
        check("s2_retrig_act", act_hi[1], 6);
        check("s2_retrig_trg", trg_hi, 6);
        check("s2_count", 32'(trig_count), 32'd3);

        // Scenario 3: coincidence of two channels.
        mode = 2'd2;
        coinc_min = 3'd2;
        clear_stats();
        pulse(4'b0001, 8);
        check("s3_single_trg", trg_hi, 0);
        clear_stats();
        trig_in = 4'b0001; tick();
        trig_in = 4'b0000; tick();
        trig_in = 4'b0100; tick();
        trig_in = 4'b0000;
        repeat (10) tick();
        check("s3_overlap_trg", trg_hi, 2);
        check("s3_count", 32'(trig_count), 32'd4);

        // Scenario 4: edge inside holdoff is discarded, edge right after is accepted.
        mode = 2'd1;
        trigger_width = 10'd3;
        holdoff = 8'd10;
        clear_stats();
        snap = -1;
        for (int i = 0; i < 30; i++) begin
            trig_in = {(i == 9 || i == 15), 2'b00, (i == 0)};
            tick();
            if (i == 14) snap = act_hi[3];
        end
        trig_in = '0;
        check("s4_holdoff_ignored", snap, 0);
        check("s4_after_idle", act_hi[3], 3);
        check("s4_count", 32'(trig_count), 32'd6);

        // Scenario 5: FORCE after reset, then saturation and clear priority.
        mode = 2'd0;
        do_reset();
        clear_stats();
        tick();
        check("s5_force_first", 32'(trigger_out), 32'd1);
        for (int i = 0; i < 20; i++) begin
            trig_in = 4'($urandom);
            tick();
        end
        trig_in = '0;
        check("s5_force_trg", trg_hi, 21);
        check("s5_force_count", 32'(trig_count), 32'd0);
        mode = 2'd1;
        trigger_width = 10'd1;
        holdoff = 8'd0;
        tick();
        for (int i = 0; i < CNT_MAX; i++) pulse(4'b0001, 5);
        check("s5_count_full", 32'(trig_count), 32'(CNT_MAX));
        for (int i = 0; i < 3; i++) pulse(4'b0001, 5);
        check("s5_count_sat", 32'(trig_count), 32'(CNT_MAX));
        trig_in = 4'b0001; tick();
        trig_in = 4'b0000;
        repeat (3) tick();
        count_clr = 1'b1; tick();
        count_clr = 1'b0;
        repeat (3) tick();
        check("s5_clr_priority", 32'(trig_count), 32'd0);

        // Scenario 6: reset mid-pulse and mid-holdoff, then a clean first pulse.
        trigger_width = 10'd8;
        holdoff = 8'd10;
        pulse(4'b0001, 5);
        do_reset();
        pulse(4'b0001, 16);
        do_reset();
        trigger_width = 10'd5;
        holdoff = 8'd0;
        clear_stats();
        pulse(4'b0001, 10);
        check("s6_act_cycles", act_hi[0], 5);
        check("s6_trg_cycles", trg_hi, 5);
        check("s6_trg_delay", first_trg - first_act, 1);
        check("s6_count", 32'(trig_count), 32'd1);

        // Randomized traffic with periodic reconfiguration.
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                mode = 2'($urandom_range(0, 3));
                coinc_min = 3'($urandom_range(0, 7));
                trigger_width = 10'($urandom_range(0, 6));
                holdoff = 8'($urandom_range(0, 5));
                ch_enable = 4'($urandom);
            end
            for (int c = 0; c < N_CH; c++) trig_in[c] = ($urandom_range(0, 3) == 0);
            count_clr = ($urandom_range(0, 30) == 0);
            tick();
        end
        count_clr = 1'b0;
        trig_in = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
